// File: rtl/booth4_seq_mult_ctrl.sv
// Sequential signed radix-4 Booth multiplier with valid/ready flow control.
// It retires one Booth digit per cycle and holds the product until the sink accepts it.
module booth4_seq_mult_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy
);
    localparam int PW    = 2 * WIDTH;
    localparam int STEPS = WIDTH / 2;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [PW-1:0]   mcand;     // sign-extended multiplicand, pre-shifted by 4^i each step
    logic [PW-1:0]   acc;
    logic [WIDTH-1:0] mplier;   // shifts right two bits per step; [1:0] is the current digit
    logic            hist;
    logic [CW-1:0]   cnt;

    logic [2:0]      trip;
    logic [PW-1:0]   pp;
    logic [PW-1:0]   acc_next;

    always_comb begin
        trip = {mplier[1:0], hist};
        pp   = '0;
        case (trip)
            3'b001, 3'b010: pp = mcand;
            3'b011:         pp = mcand << 1;
            3'b100:         pp = ~(mcand << 1) + PW'(1);
            3'b101, 3'b110: pp = ~mcand + PW'(1);
            default:        pp = '0;
        endcase
        acc_next = acc + pp;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            hist   <= 1'b0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= {{WIDTH{a[WIDTH-1]}}, a};
                        mplier <= b;
                        hist   <= 1'b0;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 2;
                    mplier <= mplier >> 2;
                    hist   <= mplier[1];
                    cnt    <= cnt + CW'(1);
                    // result only changes here, so it never exposes a partial sum
                    if (cnt == CW'(STEPS - 1)) begin
                        result <= acc_next;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN) || (state == DONE);
endmodule

// File: tb/tb_booth4_seq_mult_ctrl.sv
// Self-checking bench for booth4_seq_mult_ctrl (WIDTH=32) against an arithmetic product model.
module tb_booth4_seq_mult_ctrl;
    localparam int W = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    a = '0;
    logic [W-1:0]    b = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [2*W-1:0]  result;
    logic            busy;

    int checks = 0;
    int failures = 0;

    booth4_seq_mult_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
        longint px;
        longint py;
        px = longint'($signed(x));
        py = longint'($signed(y));
        return 64'(px * py);
    endfunction

    // Drives one operation with out_ready=1 and reports what it observed; no checking here.
    task automatic mult_op(input logic [W-1:0] x, input logic [W-1:0] y,
                           output int lat, output logic [2*W-1:0] res,
                           output logic early_ov, output logic rdy_after);
        @(negedge clk);
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        early_ov = out_valid;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            a = $urandom;
            b = $urandom;
            if (out_valid) break;
        end
        res = result;
        @(posedge clk);
        @(negedge clk);
        rdy_after = in_ready && !out_valid;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b1;
        a        = 32'd7;
        b        = 32'd9;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== '0) begin
                failures++;
                $display("FAIL reset_hold: got rdy=%b ov=%b busy=%b res=%h, need 1 0 0 0",
                         in_ready, out_valid, busy, result);
            end
        end
        in_valid = 1'b0;
        reset    = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== '0) begin
            failures++;
            $display("FAIL reset_release: got rdy=%b ov=%b busy=%b res=%h, need 1 0 0 0",
                     in_ready, out_valid, busy, result);
        end
    endtask

    task automatic test_basic();
        int lat;
        logic [2*W-1:0] res;
        logic eov, rdy;
        mult_op(32'd553524, 32'd840, lat, res, eov, rdy);
        checks++;
        if (lat !== 16 || eov !== 1'b0) begin
            failures++;
            $display("FAIL basic_latency: got %0d (early_ov=%b), need 16 (0)", lat, eov);
        end
        checks++;
        if (res !== 64'd464960160) begin
            failures++;
            $display("FAIL basic_result: got %0d, need 464960160", res);
        end
        checks++;
        if (rdy !== 1'b1) begin
            failures++;
            $display("FAIL basic_ready_return: got %b, need 1", rdy);
        end
    endtask

    task automatic test_signs_corners();
        logic [W-1:0]   xa [7];
        logic [W-1:0]   ya [7];
        logic [2*W-1:0] ea [7];
        int lat;
        logic [2*W-1:0] res;
        logic eov, rdy;
        xa = '{32'hFFFFFEFD, 32'd1, 32'hB887CAAF, 32'd0, 32'h80000000, 32'h80000000, 32'h7FFFFFFF};
        ya = '{32'hFFFFFEFD, 32'hB887CAAF, 32'd0, 32'd1348760118, 32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF};
        ea = '{64'd67081, 64'hFFFFFFFFB887CAAF, 64'd0, 64'd0,
               64'h4000000000000000, 64'hC000000080000000, 64'h3FFFFFFF00000001};
        for (int i = 0; i < 7; i++) begin
            mult_op(xa[i], ya[i], lat, res, eov, rdy);
            checks++;
            if (res !== ea[i] || lat !== 16 || rdy !== 1'b1) begin
                failures++;
                $display("FAIL sign_corner_%0d: got %h lat=%0d rdy=%b, need %h lat=16 rdy=1",
                         i, res, lat, rdy, ea[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] x, y;
        int lat;
        logic [2*W-1:0] res;
        logic eov, rdy;
        for (int i = 0; i < 10; i++) begin
            x = $urandom;
            y = $urandom;
            if (i == 0) x = 32'hFFFFFFFF;
            if (i == 1) y = 32'h55555555;
            mult_op(x, y, lat, res, eov, rdy);
            checks++;
            if (res !== model(x, y) || lat !== 16) begin
                failures++;
                $display("FAIL random_%0d: %h*%h got %h lat=%0d, need %h lat=16",
                         i, x, y, res, lat, model(x, y));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] x, y;
        logic [2*W-1:0] exp_res;
        int lat;
        logic [2*W-1:0] res;
        logic eov, rdy;
        bit held_ok;
        x = 32'hDEAD1234;
        y = 32'h0BADF00D;
        exp_res = model(x, y);
        @(negedge clk);
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_wait: out_valid never rose (got %b, need 1)", out_valid);
        end
        held_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            a        = $urandom;
            b        = $urandom;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== exp_res) held_ok = 1'b0;
        end
        checks++;
        if (!held_ok) begin
            failures++;
            $display("FAIL bp_hold: got ov=%b rdy=%b res=%h, need 1 0 %h",
                     out_valid, in_ready, result, exp_res);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== exp_res) begin
            failures++;
            $display("FAIL bp_release: got ov=%b rdy=%b res=%h, need 0 1 %h",
                     out_valid, in_ready, result, exp_res);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_single_transfer: got busy=%b ov=%b, need 0 0", busy, out_valid);
        end
        x = 32'hFFFF8001;
        y = 32'h00012345;
        mult_op(x, y, lat, res, eov, rdy);
        checks++;
        if (res !== model(x, y) || lat !== 16) begin
            failures++;
            $display("FAIL bp_next_op: got %h lat=%0d, need %h lat=16", res, lat, model(x, y));
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [2*W-1:0] res;
        logic eov, rdy;
        @(negedge clk);
        in_valid  = 1'b1;
        a         = 32'h12345678;
        b         = 32'h9ABCDEF0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_busy: got %b, need 1", busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== '0) begin
            failures++;
            $display("FAIL mid_reset_async: got rdy=%b ov=%b busy=%b res=%h, need 1 0 0 0",
                     in_ready, out_valid, busy, result);
        end
        @(negedge clk);
        reset = 1'b0;
        mult_op(32'd1348760118, 32'd1, lat, res, eov, rdy);
        checks++;
        if (res !== 64'd1348760118 || lat !== 16) begin
            failures++;
            $display("FAIL mid_after: got %0d lat=%0d, need 1348760118 lat=16", res, lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs_corners();
        test_random();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
